// File: rtl/adc_sample_averager.sv
// Block averager for ADC samples: sums 2^LOG2_N accepted samples, then publishes a registered mean.
// Optional macro ADC_AVG_ROUND_EN switches the final divide from truncation to round-half-up.
module adc_sample_averager #(
  parameter int LOG2_N = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              avg_ready,
  output logic [LOG2_N:0]   fill_count
);

  localparam int ACC_W = DATA_W + LOG2_N + 1;
  localparam int CNT_W = LOG2_N + 1;
  localparam int N     = 1 << LOG2_N;
`ifdef ADC_AVG_ROUND_EN
  // Half of the divisor; integer division makes this 0 when LOG2_N is 0.
  localparam int RND   = N / 2;
`else
  localparam int RND   = 0;
`endif

  typedef enum logic {FILL, RUN} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_p0;
  logic [ACC_W-1:0]   sum_p0;
  logic               accept;
  logic               last;

  function automatic logic [DATA_W-1:0] avg_of(input logic [ACC_W-1:0] sum);
    return DATA_W'((sum + ACC_W'(RND)) >> LOG2_N);
  endfunction

  always_comb begin
    accept  = sample_valid && !clear;
    last    = accept && (fill_count == CNT_W'(N - 1));
    sum_p0  = acc_p0 + ACC_W'(sample_in);
    state_d = state_q;
    if (last) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  assign avg_ready = (state_q == RUN);

  // Stage p0 -> p1: accumulate, and on the block's final sample publish the average.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0     <= '0;
      fill_count <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (clear) begin
        acc_p0     <= '0;
        fill_count <= '0;
      end else if (accept) begin
        if (last) begin
          acc_p0     <= '0;
          fill_count <= '0;
          avg_out    <= avg_of(sum_p0);
          avg_valid  <= 1'b1;
        end else begin
          acc_p0     <= sum_p0;
          fill_count <= fill_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: three instances (LOG2_N = 0, 2, 3) checked against a scoreboard.
module tb_adc_sample_averager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] sin0, sin2, sin3;
  logic       sv0, sv2, sv3;
  logic       cl0, cl2, cl3;
  logic [7:0] ao0, ao2, ao3;
  logic       av0, av2, av3;
  logic       ar0, ar2, ar3;
  logic [0:0] fc0;
  logic [2:0] fc2;
  logic [3:0] fc3;

  adc_sample_averager #(.LOG2_N(0), .DATA_W(8)) u_l0 (
    .clk(clk), .reset(reset), .sample_in(sin0), .sample_valid(sv0), .clear(cl0),
    .avg_out(ao0), .avg_valid(av0), .avg_ready(ar0), .fill_count(fc0));
  adc_sample_averager #(.LOG2_N(2), .DATA_W(8)) u_l2 (
    .clk(clk), .reset(reset), .sample_in(sin2), .sample_valid(sv2), .clear(cl2),
    .avg_out(ao2), .avg_valid(av2), .avg_ready(ar2), .fill_count(fc2));
  adc_sample_averager #(.LOG2_N(3), .DATA_W(8)) u_l3 (
    .clk(clk), .reset(reset), .sample_in(sin3), .sample_valid(sv3), .clear(cl3),
    .avg_out(ao3), .avg_valid(av3), .avg_ready(ar3), .fill_count(fc3));

  typedef struct {int k; int v;} exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int m_sum[3];
  int m_cnt[3];
  int pulses[3];

  // Instance index 0/1/2 maps to LOG2_N 0/2/3.
  function automatic int lg_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic int model_avg(input int k, input int sum);
    int l;
    int r;
    l = lg_of(k);
    r = 0;
`ifdef ADC_AVG_ROUND_EN
    if (l > 0) r = 1 << (l - 1);
`endif
    return (sum + r) >> l;
  endfunction

  function automatic logic [31:0] fill_of(input int k);
    return (k == 0) ? 32'(fc0) : ((k == 1) ? 32'(fc2) : 32'(fc3));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic sb_pop(input int k, input logic [31:0] val);
    exp_t e;
    pulses[k]++;
    check("sb_pulse_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_instance", 32'(k), 32'(e.k));
      check("sb_avg_out", val, 32'(e.v));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (av0 === 1'b1) sb_pop(0, 32'(ao0));
    if (av2 === 1'b1) sb_pop(1, 32'(ao2));
    if (av3 === 1'b1) sb_pop(2, 32'(ao3));
  endtask

  task automatic drive(input int k, input int d, input bit v, input bit c);
    case (k)
      0:       begin sin0 = 8'(d); sv0 = v; cl0 = c; end
      1:       begin sin2 = 8'(d); sv2 = v; cl2 = c; end
      default: begin sin3 = 8'(d); sv3 = v; cl3 = c; end
    endcase
    if (c) begin
      m_sum[k] = 0;
      m_cnt[k] = 0;
    end else if (v) begin
      m_sum[k] += d;
      m_cnt[k]++;
      if (m_cnt[k] == (1 << lg_of(k))) begin
        sb.push_back('{k, model_avg(k, m_sum[k])});
        m_sum[k] = 0;
        m_cnt[k] = 0;
      end
    end
    tick();
    case (k)
      0:       begin sv0 = 1'b0; cl0 = 1'b0; end
      1:       begin sv2 = 1'b0; cl2 = 1'b0; end
      default: begin sv3 = 1'b0; cl3 = 1'b0; end
    endcase
  endtask

  initial begin
    int p;
    int vals[4];
    reset = 1'b0;
    sin0 = '0; sin2 = '0; sin3 = '0;
    sv0 = 1'b0; sv2 = 1'b0; sv3 = 1'b0;
    cl0 = 1'b0; cl2 = 1'b0; cl3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0; pulses[i] = 0;
    end

    #12;
    check("rst_avg_out", 32'(ao3), 32'd0);
    check("rst_fill_count", 32'(fc3), 32'd0);
    check("rst_avg_valid", 32'(av3), 32'd0);
    check("rst_avg_ready", 32'(ar3), 32'd0);
    check("rst_avg_ready_l2", 32'(ar2), 32'd0);
    #5 reset = 1'b1;

    // Four-sample block: 10,20,30,42 (sum 102)
    vals = '{10, 20, 30, 42};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("l2_ready_before_first", 32'(ar2), 32'd0);
      drive(1, vals[i], 1'b1, 1'b0);
      check("l2_fill_count", fill_of(1), 32'(m_cnt[1]));
    end
    check("l2_pulses", 32'(pulses[1]), 32'd1);
    check("l2_ready_rises", 32'(ar2), 32'd1);
    drive(1, 0, 1'b0, 1'b0);
    check("l2_valid_one_cycle", 32'(av2), 32'd0);
    check("l2_avg_holds", 32'(ao2), 32'(model_avg(1, 102)));

    // Full-scale block, with idle cycles mid-block
    drive(1, 255, 1'b1, 1'b0);
    drive(1, 255, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1, 77, 1'b0, 1'b0);
    check("l2_hold_when_idle", fill_of(1), 32'd2);
    drive(1, 255, 1'b1, 1'b0);
    drive(1, 255, 1'b1, 1'b0);
    check("l2_full_scale", 32'(ao2), 32'd255);
    check("l2_fill_wraps", fill_of(1), 32'd0);
    check("l2_pulses_total", 32'(pulses[1]), 32'd2);

    // LOG2_N = 0: each sample is its own average
    drive(0, 7, 1'b1, 1'b0);
    check("l0_first", 32'(ao0), 32'd7);
    drive(0, 9, 1'b1, 1'b0);
    check("l0_second", 32'(ao0), 32'd9);
    check("l0_pulses", 32'(pulses[0]), 32'd2);
    drive(0, 0, 1'b0, 1'b0);
    check("l0_valid_drops", 32'(av0), 32'd0);

    // Eight-sample block, then partial block discarded by clear
    for (int i = 0; i < 8; i++) drive(2, 60, 1'b1, 1'b0);
    check("l3_first_avg", 32'(ao3), 32'd60);
    for (int i = 0; i < 5; i++) drive(2, 30 + i, 1'b1, 1'b0);
    check("l3_partial_fill", fill_of(2), 32'd5);
    drive(2, 0, 1'b0, 1'b1);
    check("clr_fill_zero", fill_of(2), 32'd0);
    check("clr_avg_unchanged", 32'(ao3), 32'd60);
    check("clr_ready_kept", 32'(ar3), 32'd1);
    check("clr_no_pulse", 32'(av3), 32'd0);
    p = pulses[2];
    for (int i = 0; i < 8; i++) drive(2, 100, 1'b1, 1'b0);
    check("clr_one_pulse", 32'(pulses[2] - p), 32'd1);
    check("clr_avg_100", 32'(ao3), 32'd100);

    // clear beats a simultaneous sample
    for (int i = 0; i < 3; i++) drive(2, 10, 1'b1, 1'b0);
    drive(2, 200, 1'b1, 1'b1);
    check("clr_wins_fill", fill_of(2), 32'd0);
    for (int i = 0; i < 8; i++) drive(2, 8, 1'b1, 1'b0);
    check("clr_wins_avg", 32'(ao3), 32'd8);

    // Asynchronous reset between edges, mid-block
    for (int i = 0; i < 3; i++) drive(2, 50, 1'b1, 1'b0);
    check("rst_mid_fill", fill_of(2), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("arst_avg_out", 32'(ao3), 32'd0);
    check("arst_fill_count", 32'(fc3), 32'd0);
    check("arst_avg_valid", 32'(av3), 32'd0);
    check("arst_avg_ready", 32'(ar3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_cnt[i] = 0;
    end
    #3 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("post_rst_ready_low", 32'(ar3), 32'd0);
      drive(2, 50, 1'b1, 1'b0);
    end
    check("post_rst_avg", 32'(ao3), 32'd50);
    check("post_rst_ready", 32'(ar3), 32'd1);
    drive(2, 0, 1'b0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 Parameter: LOG2_N, default 3, log2 of samples per block; legal range 0..6.
REQ-002 Parameter: DATA_W, default 8, sample and average width in bits.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: sample_in  input  DATA_W  unsigned ADC conversion result from the ADC interface stage.
REQ-006 Port: sample_valid  input  1  one-cycle strobe; sample_in is valid in that cycle.
REQ-007 Port: clear  input  1  synchronous restart of the current block.
REQ-008 Port: avg_out  output  DATA_W  registered block average, feeding the binary-to-BCD stage.
REQ-009 Port: avg_valid  output  1  one-cycle strobe marking a new avg_out.
REQ-010 Port: avg_ready  output  1  level; high once the first average since reset has been produced.
REQ-011 Port: fill_count  output  LOG2_N+1  number of samples accumulated in the current block.

Function
REQ-012 The accumulator SHALL be DATA_W+LOG2_N+1 bits, so that no sum can overflow.
REQ-013 The FSM SHALL have two states: FILL (no average produced yet) and RUN (at least one average produced); avg_ready = (state == RUN).
REQ-014 On sample_valid with clear low, the block SHALL add sample_in to the accumulator and increment fill_count.
REQ-015 When the accepted sample is sample number 2^LOG2_N of the block, the same edge SHALL load avg_out, pulse avg_valid, zero the accumulator and fill_count, and move FILL to RUN.
REQ-016 avg_out SHALL equal (sum of the block's samples + R) >> LOG2_N, where R is defined under Configuration.
REQ-017 avg_valid SHALL be high for exactly one cycle: the cycle after the edge that accepted the final sample (latency one clock).
REQ-018 avg_out SHALL hold its value between blocks and SHALL change only on avg_valid edges.
REQ-019 With LOG2_N = 0, every accepted sample SHALL produce an average equal to that sample, one cycle later.
REQ-020 clear SHALL zero the accumulator and fill_count on the next edge without changing avg_out, avg_ready, or the state.
REQ-021 When clear and sample_valid are high in the same cycle, clear SHALL win and the sample SHALL be discarded.
REQ-022 When sample_valid is low, the accumulator and fill_count SHALL hold.

Reset
REQ-023 While reset is low, avg_out, fill_count, the accumulator and avg_valid SHALL be 0 and the state SHALL be FILL; this applies immediately, independent of clk.
REQ-024 Reset asserted mid-block SHALL discard the partial sum; after release, the first accepted sample starts a new block.

Configuration
REQ-025 With the macro ADC_AVG_ROUND_EN defined, R SHALL be 2^(LOG2_N-1) when LOG2_N > 0 (round-half-up); without it, R SHALL be 0 (truncation); for LOG2_N = 0, R SHALL be 0 in both builds.

Verification
REQ-026 LOG2_N=2, samples 10,20,30,42 -> one avg_valid pulse; avg_out = 25 without ADC_AVG_ROUND_EN, 26 with it; avg_ready rises.
REQ-027 LOG2_N=2, four samples of 255 -> avg_out = 255 in both builds (no overflow); fill_count returns to 0.
REQ-028 LOG2_N=3, accept 5 samples, pulse clear, then send 8 samples of 100 -> exactly one avg_valid, avg_out = 100, and avg_out is unchanged during clear.
REQ-029 clear and sample_valid (value 200) in the same cycle -> fill_count = 0 and the sample is excluded from the next average.
REQ-030 Reset asserted mid-block after 3 samples, between clock edges -> outputs go to 0 at once; after release, 8 samples of 50 -> avg_out = 50 and avg_ready rises.
REQ-031 LOG2_N=0, sample_valid on consecutive cycles with values 7, 9 -> avg_valid high in each following cycle; avg_out = 7, then 9.
